// File: rtl/bcd_press_pkg.sv
// Shared types and constants for the BCD press counter and its ASCII report stream.
package bcd_press_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIGIT,
        S_CR,
        S_LF
    } rpt_state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One decimal digit of the up/down counter; carry/borrow ripple to the next digit.
module bcd_digit_updown (
    input  logic [3:0] digit,
    input  logic       inc_en,
    input  logic       dec_en,
    input  logic       clr,
    output logic [3:0] digit_next,
    output logic       carry_out,
    output logic       borrow_out
);

    always_comb begin
        carry_out  = inc_en && (digit == 4'd9);
        borrow_out = dec_en && (digit == 4'd0);
        digit_next = digit;
        if (clr)
            digit_next = 4'd0;
        else if (inc_en)
            digit_next = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        else if (dec_en)
            digit_next = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end

endmodule

// File: rtl/bcd_press_counter.sv
// BCD up/down press counter with a coalescing ASCII report stream ("dddd\r\n").
module bcd_press_counter
    import bcd_press_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_pulse,
    input  logic                  dec_pulse,
    input  logic                  clr_pulse,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [7:0]            evt_data
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] count_q, count_n;
    logic [DIGITS:0]     inc_chain, dec_chain;
    logic                chain_top_unused;
    logic                change;

    assign inc_chain[0] = inc_pulse & ~dec_pulse & ~clr_pulse;
    assign dec_chain[0] = dec_pulse & ~inc_pulse & ~clr_pulse;
    assign change       = clr_pulse | (inc_pulse ^ dec_pulse);
    // Wrap-around falls out of the digits themselves; the last carry/borrow has no consumer.
    assign chain_top_unused = inc_chain[DIGITS] | dec_chain[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_updown u_digit (
            .digit      (count_q[4*g +: 4]),
            .inc_en     (inc_chain[g]),
            .dec_en     (dec_chain[g]),
            .clr        (clr_pulse),
            .digit_next (count_n[4*g +: 4]),
            .carry_out  (inc_chain[g+1]),
            .borrow_out (dec_chain[g+1])
        );
    end

    rpt_state_e          state_q, state_n;
    logic [IDX_W-1:0]    idx_q, idx_n;
    logic [4*DIGITS-1:0] snap_q, snap_n;
    logic                pend_q, pend_n;
    logic [7:0]          data_n;
    logic                hs;

    assign hs = evt_valid & evt_ready;

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        snap_n  = snap_q;
        pend_n  = pend_q;
        case (state_q)
            S_IDLE: begin
                if (change) begin
                    snap_n  = count_n;
                    idx_n   = IDX_LAST;
                    state_n = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (change) pend_n = 1'b1;
                if (hs) begin
                    if (idx_q == '0) state_n = S_CR;
                    else             idx_n   = idx_q - 1'b1;
                end
            end
            S_CR: begin
                if (change) pend_n = 1'b1;
                if (hs) state_n = S_LF;
            end
            S_LF: begin
                if (hs) begin
                    if (pend_q || change) begin
                        snap_n  = count_n;
                        pend_n  = 1'b0;
                        idx_n   = IDX_LAST;
                        state_n = S_DIGIT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (change) begin
                    pend_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Output byte is computed from the next state so evt_data is a clean register.
        case (state_n)
            S_DIGIT: data_n = bcd_to_ascii(snap_n[4*idx_n +: 4]);
            S_CR:    data_n = ASCII_CR;
            S_LF:    data_n = ASCII_LF;
            default: data_n = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            state_q   <= S_IDLE;
            idx_q     <= '0;
            snap_q    <= '0;
            pend_q    <= 1'b0;
            evt_valid <= 1'b0;
            evt_data  <= 8'h00;
        end else begin
            count_q   <= count_n;
            state_q   <= state_n;
            idx_q     <= idx_n;
            snap_q    <= snap_n;
            pend_q    <= pend_n;
            evt_valid <= (state_n != S_IDLE);
            evt_data  <= data_n;
        end
    end

    assign count_bcd = count_q;

endmodule

// File: tb/tb_bcd_press_counter.sv
// Directed bench for bcd_press_counter: integer/queue reference model checked every cycle plus literal report checks.
module tb_bcd_press_counter;

    localparam int D   = 4;
    localparam int MOD = 10000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           inc_pulse = 1'b0, dec_pulse = 1'b0, clr_pulse = 1'b0;
    logic           evt_ready = 1'b0;
    logic [4*D-1:0] count_bcd;
    logic           evt_valid;
    logic [7:0]     evt_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_press_counter #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_pulse (inc_pulse),
        .dec_pulse (dec_pulse),
        .clr_pulse (clr_pulse),
        .count_bcd (count_bcd),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference model: decimal integer counter and a byte queue holding the report in flight.
    int          m_count = 0;
    bit          m_busy = 0, m_pend = 0;
    byte unsigned m_q[$];
    bit          m_chg, m_hs;
    int          m_nc;

    task automatic load_report(input int v);
        byte unsigned tmp[D];
        int t;
        t = v;
        for (int i = 0; i < D; i++) begin
            tmp[i] = 8'(48 + t % 10);
            t = t / 10;
        end
        m_q.delete();
        for (int i = D - 1; i >= 0; i--) m_q.push_back(tmp[i]);
        m_q.push_back(8'h0D);
        m_q.push_back(8'h0A);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_count = 0; m_busy = 0; m_pend = 0; m_q.delete();
        end else begin
            m_chg = clr_pulse || (inc_pulse != dec_pulse);
            if (clr_pulse)                   m_nc = 0;
            else if (inc_pulse && !dec_pulse) m_nc = (m_count + 1) % MOD;
            else if (dec_pulse && !inc_pulse) m_nc = (m_count + MOD - 1) % MOD;
            else                              m_nc = m_count;
            m_hs = m_busy && evt_ready;
            if (!m_busy) begin
                if (m_chg) begin load_report(m_nc); m_busy = 1; end
            end else if (m_hs) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    if (m_pend || m_chg) begin load_report(m_nc); m_pend = 0; end
                    else m_busy = 0;
                end else if (m_chg) m_pend = 1;
            end else if (m_chg) m_pend = 1;
            m_count = m_nc;
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("model_count", count_bcd, to_bcd(m_count));
            chk("model_valid", evt_valid, m_busy);
            if (m_busy && m_q.size() > 0) chk("model_data", evt_data, m_q[0]);
        end
    end

    // Log of bytes actually accepted from the DUT.
    byte unsigned got[$];
    initial forever begin
        @(posedge clk);
        if (rst_n && evt_valid === 1'b1 && evt_ready === 1'b1) got.push_back(evt_data);
    end

    task automatic expect_rpts(input string name, input string digits);
        byte unsigned exp[$];
        bit ok;
        int bad;
        for (int i = 0; i < digits.len(); i++) begin
            exp.push_back(digits[i]);
            if (i % D == D - 1) begin exp.push_back(8'h0D); exp.push_back(8'h0A); end
        end
        ok = (got.size() == exp.size());
        bad = -1;
        for (int i = 0; ok && i < exp.size(); i++)
            if (got[i] != exp[i]) begin ok = 0; bad = i; end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d bytes (first diff at %0d) expected %0d bytes for \"%s\"+CRLF",
                     name, got.size(), bad, exp.size(), digits);
        end
        got.delete();
    endtask

    task automatic pulse(input bit i, input bit d, input bit c);
        inc_pulse = i; dec_pulse = d; clr_pulse = c;
        @(negedge clk);
        inc_pulse = 0; dec_pulse = 0; clr_pulse = 0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (evt_valid !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, (n >= 200), 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_count", count_bcd, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_data",  evt_data,  0);
        rst_n = 1; evt_ready = 1;
        @(negedge clk);

        pulse(1, 0, 0);
        chk("inc_count", count_bcd, 16'h0001);
        chk("inc_valid", evt_valid, 1);
        chk("inc_msd",   evt_data,  8'h30);
        wait_idle("inc");
        expect_rpts("inc_report", "0001");
        chk("inc_valid_drop", evt_valid, 0);

        pulse(0, 0, 1);
        wait_idle("clr");
        expect_rpts("clr_report", "0000");

        pulse(0, 1, 0);
        chk("dec_wrap_count", count_bcd, 16'h9999);
        wait_idle("dec0");
        expect_rpts("dec_wrap_report", "9999");

        pulse(1, 0, 0);
        chk("inc_wrap_count", count_bcd, 16'h0000);
        wait_idle("inc9");
        expect_rpts("inc_wrap_report", "0000");

        pulse(0, 1, 0);
        chk("dec_wrap2_count", count_bcd, 16'h9999);
        wait_idle("dec1");
        expect_rpts("dec_wrap2_report", "9999");

        pulse(1, 1, 0);
        chk("incdec_count", count_bcd, 16'h9999);
        chk("incdec_valid", evt_valid, 0);
        repeat (3) @(negedge clk);
        chk("incdec_valid_late", evt_valid, 0);
        expect_rpts("incdec_none", "");

        pulse(0, 0, 1);
        wait_idle("clr2");
        got.delete();
        repeat (42) pulse(1, 0, 0);
        wait_idle("inc42");
        chk("inc42_count", count_bcd, 16'h0042);
        got.delete();

        pulse(1, 0, 1);
        chk("clrinc_count", count_bcd, 16'h0000);
        wait_idle("clrinc");
        expect_rpts("clrinc_report", "0000");

        // Back-pressure with coalescing.
        rst_n = 0; @(negedge clk); rst_n = 1; evt_ready = 0; @(negedge clk);
        got.delete();
        pulse(1, 0, 0);
        chk("stall_first", evt_data, 8'h30);
        repeat (3) begin
            pulse(1, 0, 0);
            chk("stall_data", evt_data, 8'h30);
            chk("stall_valid", evt_valid, 1);
        end
        chk("stall_count", count_bcd, 16'h0004);
        evt_ready = 1;
        wait_idle("coalesce");
        expect_rpts("coalesce_report", "00010004");

        // Reset while the CR byte is on the bus.
        evt_ready = 0;
        pulse(1, 0, 0);
        evt_ready = 1;
        repeat (4) @(negedge clk);
        evt_ready = 0;
        chk("cr_byte", evt_data, 8'h0D);
        chk("cr_digits_sent", got.size(), 4);
        got.delete();
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", evt_valid, 0);
        chk("async_rst_count", count_bcd, 0);
        chk("async_rst_data",  evt_data,  0);
        @(negedge clk);
        rst_n = 1; evt_ready = 1;
        repeat (10) @(negedge clk);
        chk("post_rst_valid", evt_valid, 0);
        chk("post_rst_bytes", got.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
